// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch controller
package fetch_pkg;

  localparam int INSN_WIDTH = 32;
  localparam logic [INSN_WIDTH-1:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - two-entry synchronous FIFO with flush, head read combinationally
module fetch_queue #(
  parameter int DATA_W = 42,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == 2'(DEPTH));
  assign empty = (count_q == 2'd0);
  assign rdata = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencer feeding a fetch queue; FETCH_MISALIGN_CHECK_EN adds misaligned redirect trap
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                    size_address = 10,
  parameter logic [size_address-1:0] RESET_PC   = '0,
  parameter int                    QUEUE_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                    misaligned_error,
`endif
  input  logic                    fetch_enable,
  input  logic                    redirect_valid,
  input  logic [size_address-1:0] redirect_pc,
  output logic [size_address-1:0] imem_address,
  input  logic [INSN_WIDTH-1:0]   imem_instruction,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSN_WIDTH-1:0]   out_instruction,
  output logic [size_address-1:0] out_pc,
  output logic                    halted
);

  localparam int QW = INSN_WIDTH + size_address;

  fetch_state_t            state_q, state_d;
  logic [size_address-1:0] pc_q, pc_d;
  logic                    halted_q, halted_d;
  logic                    q_full, q_empty;
  logic                    push, pop;
  logic [QW-1:0]           q_rdata;
  logic [size_address-1:0] redirect_aligned;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic                    misaligned_q, misaligned_d;
  assign misaligned_error = misaligned_q;
`endif

  assign redirect_aligned = redirect_pc & ~size_address'(3);

  // Redirect suppresses both queue operations; the queue sees it as a flush.
  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = (state_q == RUN) && fetch_enable && !redirect_valid && (!q_full || pop);

  fetch_queue #(
    .DATA_W (QW),
    .DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_instruction, pc_q}),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty)
  );

  assign imem_address    = pc_q;
  assign out_valid       = !q_empty;
  assign out_instruction = q_rdata[QW-1:size_address];
  assign out_pc          = q_rdata[size_address-1:0];
  assign halted          = halted_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned_d = misaligned_q;
`endif
    if (redirect_valid) begin
      pc_d = redirect_aligned;
      if (state_q == HALTED) begin
        state_d = fetch_enable ? RUN : IDLE;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d      = HALTED;
        misaligned_d = 1'b1;
      end
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (fetch_enable) state_d = RUN;
        end
        RUN: begin
          if (push) begin
            pc_d = pc_q + size_address'(4);
            if (imem_instruction == EBREAK_INSN) state_d = HALTED;
          end else if (!fetch_enable) begin
            state_d = IDLE;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

endmodule
